// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle renderer: FSM state type and default geometry/colours.
package paddle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } state_e;

  localparam int unsigned DefScreenW = 120;
  localparam int unsigned DefPadW    = 7;
  localparam int unsigned DefPadH    = 3;
  localparam int unsigned DefYTop    = 112;
  localparam int unsigned DefXW      = 8;
  localparam int unsigned DefYW      = 7;
  localparam int unsigned DefCW      = 3;
  localparam logic [2:0]  DefFg      = 3'b001;
  localparam logic [2:0]  DefBg      = 3'b000;

endpackage

// File: rtl/span_calc.sv
// Combinational span logic: clamps the requested centre and picks the column range to sweep.
module span_calc import paddle_pkg::*; #(
  parameter int unsigned SCREEN_W = DefScreenW,
  parameter int unsigned PAD_W    = DefPadW,
  parameter int unsigned X_W      = DefXW
) (
  input  logic [X_W-1:0] i_position,
  input  logic [X_W-1:0] i_old_lo,
  input  logic [X_W-1:0] i_old_hi,
  input  logic           i_old_valid,
  input  logic           i_delta,
  output logic [X_W-1:0] o_lo,
  output logic [X_W-1:0] o_hi,
  output logic [X_W-1:0] o_first_col,
  output logic [X_W-1:0] o_last_col
);

  localparam int unsigned HALF = (PAD_W - 1) / 2;
  // One extra bit so positions at or beyond SCREEN_W clamp instead of wrapping.
  localparam logic [X_W:0] PcMin = (X_W + 1)'(HALF);
  localparam logic [X_W:0] PcMax = (X_W + 1)'(SCREEN_W - 1 - HALF);

  logic [X_W:0] w_pos;
  logic [X_W:0] w_pc;

  always_comb begin
    w_pos = {1'b0, i_position};
    if (w_pos < PcMin) begin
      w_pc = PcMin;
    end else if (w_pos > PcMax) begin
      w_pc = PcMax;
    end else begin
      w_pc = w_pos;
    end

    o_lo = X_W'(w_pc - PcMin);
    o_hi = X_W'(w_pc + PcMin);

    if (i_delta && i_old_valid) begin
      o_first_col = (i_old_lo < o_lo) ? i_old_lo : o_lo;
      o_last_col  = (i_old_hi > o_hi) ? i_old_hi : o_hi;
    end else begin
      o_first_col = '0;
      o_last_col  = X_W'(SCREEN_W - 1);
    end
  end

endmodule

// File: rtl/paddle_renderer.sv
// Column-major pixel-stream renderer for a horizontal paddle with start/done handshake and
// delta redraw of only the columns touched by the old and new spans.
module paddle_renderer import paddle_pkg::*; #(
  parameter int unsigned     SCREEN_W = DefScreenW,
  parameter int unsigned     PAD_W    = DefPadW,
  parameter int unsigned     PAD_H    = DefPadH,
  parameter int unsigned     Y_TOP    = DefYTop,
  parameter int unsigned     X_W      = DefXW,
  parameter int unsigned     Y_W      = DefYW,
  parameter int unsigned     C_W      = DefCW,
  parameter logic [C_W-1:0]  FG       = DefFg,
  parameter logic [C_W-1:0]  BG       = DefBg
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           delta,
  input  logic [X_W-1:0] position,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] color,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam logic [Y_W-1:0] YFirst = Y_W'(Y_TOP);
  localparam logic [Y_W-1:0] YLast  = Y_W'(Y_TOP + PAD_H - 1);

  state_e         r_state, w_state_d;
  logic [X_W-1:0] r_x, w_x_d;
  logic [Y_W-1:0] r_y, w_y_d;
  logic [C_W-1:0] r_color, w_color_d;
  logic           r_plot, w_plot_d;
  logic           r_busy, w_busy_d;
  logic           r_done, w_done_d;
  logic [X_W-1:0] r_lo, w_lo_d;
  logic [X_W-1:0] r_hi, w_hi_d;
  logic [X_W-1:0] r_last, w_last_d;
  logic [X_W-1:0] r_old_lo, w_old_lo_d;
  logic [X_W-1:0] r_old_hi, w_old_hi_d;
  logic           r_old_valid, w_old_valid_d;

  logic [X_W-1:0] w_span_lo, w_span_hi, w_span_first, w_span_last;

  span_calc #(
    .SCREEN_W (SCREEN_W),
    .PAD_W    (PAD_W),
    .X_W      (X_W)
  ) u_span_calc (
    .i_position  (position),
    .i_old_lo    (r_old_lo),
    .i_old_hi    (r_old_hi),
    .i_old_valid (r_old_valid),
    .i_delta     (delta),
    .o_lo        (w_span_lo),
    .o_hi        (w_span_hi),
    .o_first_col (w_span_first),
    .o_last_col  (w_span_last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_y         <= '0;
      r_color     <= '0;
      r_plot      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_last      <= '0;
      r_old_lo    <= '0;
      r_old_hi    <= '0;
      r_old_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_x         <= w_x_d;
      r_y         <= w_y_d;
      r_color     <= w_color_d;
      r_plot      <= w_plot_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_lo        <= w_lo_d;
      r_hi        <= w_hi_d;
      r_last      <= w_last_d;
      r_old_lo    <= w_old_lo_d;
      r_old_hi    <= w_old_hi_d;
      r_old_valid <= w_old_valid_d;
    end
  end

  // Output registers double as the column/row counters while drawing.
  always_comb begin
    w_state_d     = r_state;
    w_x_d         = '0;
    w_y_d         = '0;
    w_color_d     = '0;
    w_plot_d      = 1'b0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    w_lo_d        = r_lo;
    w_hi_d        = r_hi;
    w_last_d      = r_last;
    w_old_lo_d    = r_old_lo;
    w_old_hi_d    = r_old_hi;
    w_old_valid_d = r_old_valid;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_lo_d    = w_span_lo;
          w_hi_d    = w_span_hi;
          w_last_d  = w_span_last;
          w_x_d     = w_span_first;
          w_y_d     = YFirst;
          w_plot_d  = 1'b1;
          w_busy_d  = 1'b1;
          w_state_d = StDraw;
        end
      end
      StDraw: begin
        if (r_x == r_last && r_y == YLast) begin
          w_done_d  = 1'b1;
          w_state_d = StDone;
        end else begin
          w_plot_d = 1'b1;
          w_busy_d = 1'b1;
          if (r_y == YLast) begin
            w_x_d = r_x + X_W'(1);
            w_y_d = YFirst;
          end else begin
            w_x_d = r_x;
            w_y_d = r_y + Y_W'(1);
          end
        end
      end
      StDone: begin
        w_old_lo_d    = r_lo;
        w_old_hi_d    = r_hi;
        w_old_valid_d = 1'b1;
        w_state_d     = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    if (w_plot_d) begin
      w_color_d = (w_x_d >= w_lo_d && w_x_d <= w_hi_d) ? FG : BG;
    end
  end

  assign x     = r_x;
  assign y     = r_y;
  assign color = r_color;
  assign plot  = r_plot;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_paddle_renderer.sv
// Self-checking bench: directed and random draws compared cycle by cycle against a
// pixel-list model built from the clamp/span rules.
module tb_paddle_renderer;

  localparam int SW   = 120;
  localparam int PW   = 7;
  localparam int PH   = 3;
  localparam int YT   = 112;
  localparam int HALF = (PW - 1) / 2;
  localparam int FGC  = 1;
  localparam int BGC  = 0;

  logic       clock;
  logic       reset;
  logic       start;
  logic       delta;
  logic [7:0] position;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  // Model of the remembered span from the last completed draw.
  bit m_valid;
  int m_old_lo;
  int m_old_hi;

  paddle_renderer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .delta    (delta),
    .position (position),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [20:0] pack(input int p, input int b, input int d, input int cx,
                                       input int cy, input int cc);
    return {1'(p), 1'(b), 1'(d), 8'(cx), 7'(cy), 3'(cc)};
  endfunction

  function automatic logic [20:0] observed();
    return {plot, busy, done, x, y, color};
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge of the following idle cycle.
  task automatic run_sweep(input string tag, input int pos, input bit dlt,
                           input int start_at, input int reset_at);
    int pc, lo, hi, first, last, idx, cc;
    pc = pos;
    if (pc < HALF) pc = HALF;
    if (pc > SW - 1 - HALF) pc = SW - 1 - HALF;
    lo = pc - HALF;
    hi = pc + HALF;
    if (dlt && m_valid) begin
      first = (m_old_lo < lo) ? m_old_lo : lo;
      last  = (m_old_hi > hi) ? m_old_hi : hi;
    end else begin
      first = 0;
      last  = SW - 1;
    end

    start    = 1'b1;
    delta    = dlt;
    position = 8'(pos);
    @(negedge clock);
    start    = 1'b0;
    delta    = 1'($urandom_range(0, 1));
    position = 8'($urandom_range(0, 255));

    idx = 0;
    for (int c = first; c <= last; c++) begin
      for (int r = 0; r < PH; r++) begin
        cc = (c >= lo && c <= hi) ? FGC : BGC;
        check(tag, observed(), pack(1, 1, 0, c, YT + r, cc));
        if (idx == reset_at) begin
          reset = 1'b0;
          @(negedge clock);
          check({tag, "_reset"}, observed(), pack(0, 0, 0, 0, 0, 0));
          reset   = 1'b1;
          m_valid = 1'b0;
          return;
        end
        if (idx == start_at) begin
          start    = 1'b1;
          position = 8'd10;
        end
        @(negedge clock);
        start = 1'b0;
        idx++;
      end
    end
    check({tag, "_done"}, observed(), pack(0, 0, 1, 0, 0, 0));
    m_old_lo = lo;
    m_old_hi = hi;
    m_valid  = 1'b1;
    @(negedge clock);
    check({tag, "_idle"}, observed(), pack(0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m_old_lo = 0;
    m_old_hi = 0;
    reset    = 1'b0;
    start    = 1'b0;
    delta    = 1'b0;
    position = '0;

    repeat (3) @(negedge clock);
    check("reset_state", observed(), pack(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset", observed(), pack(0, 0, 0, 0, 0, 0));

    run_sweep("delta_no_old", 30, 1'b1, -1, -1);
    run_sweep("full_60", 60, 1'b0, -1, -1);
    run_sweep("delta_62", 62, 1'b1, -1, -1);
    run_sweep("clamp_0", 0, 1'b0, -1, -1);
    run_sweep("clamp_200", 200, 1'b0, -1, -1);
    run_sweep("full_60b", 60, 1'b0, -1, -1);
    run_sweep("start_ignored", 60, 1'b0, 50, -1);
    run_sweep("delta_after_ignore", 63, 1'b1, -1, -1);
    run_sweep("reset_abort", 100, 1'b1, -1, 100);
    run_sweep("delta_after_reset", 40, 1'b1, -1, -1);

    for (int i = 0; i < 10; i++) begin
      run_sweep("random", int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_renderer.md
# paddle_renderer

Parametrised pixel-stream renderer for a horizontal paddle of configurable size, position and colour. It sits between the player-position source (mouse or keyboard tracker) and the VGA framebuffer write port, and emits one pixel per cycle. It adds two things over a fixed-size catcher drawer: a start/done handshake, and a delta mode that rewrites only the columns that changed since the last draw.

## Interface
- SCREEN_W, default 120: visible columns; x range 0..SCREEN_W-1.
- PAD_W, default 7: paddle width in pixels; must be odd and ≥1.
- PAD_H, default 3: paddle height in rows.
- Y_TOP, default 112: first paddle row.
- X_W, default 8: x and position width.
- Y_W, default 7: y width.
- C_W, default 3: colour width.
- FG, default 3'b001: paddle colour.
- BG, default 3'b000: erase colour.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle request to draw; sampled only in IDLE.
- delta  in  1  sampled with start; 1 = delta sweep, 0 = full sweep.
- position  in  X_W  requested paddle centre column; sampled with start.
- x  out  X_W  pixel column.
- y  out  Y_W  pixel row.
- color  out  C_W  pixel colour.
- plot  out  1  write strobe; x/y/color are valid only while plot=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel.

## Operation
- HALF = (PAD_W-1)/2.
- Clamp: pc = position clamped to [HALF, SCREEN_W-1-HALF]. New span is lo = pc-HALF, hi = pc+HALF.
- Pixel colour is FG if lo ≤ col ≤ hi, else BG.
- Full sweep covers columns 0..SCREEN_W-1.
- Delta sweep covers columns min(old_lo, lo)..max(old_hi, hi).
  - old_lo/old_hi are the span of the previous completed draw.
  - If old_valid=0, a delta request runs as a full sweep.
- Scan order is column-major: for each column, y steps Y_TOP..Y_TOP+PAD_H-1, then the column increments.
- State machine:
  - IDLE: outputs idle. On start=1, latch pc/lo/hi/mode, compute the first and last column, go to DRAW.
  - DRAW: plot=1 every cycle. After the pixel (last col, last row), go to DONE.
  - DONE: done=1 for one cycle; old_lo/old_hi ← lo/hi; old_valid ← 1; go to IDLE.
- start is ignored in DRAW and DONE; it is not queued.
- position changes after acceptance have no effect.
- Arithmetic:
  - Clamping compares in X_W+1 bits, so position ≥ SCREEN_W cannot wrap.
  - The column counter never exceeds SCREEN_W-1.
- Reset (reset=0) in any state:
  - State → IDLE.
  - x, y, color, plot, busy, done → 0.
  - old_valid → 0.
  - Any sweep in progress is abandoned with no done pulse.

## Timing
- Reset values are all outputs 0. State is IDLE, old_valid=0, old_lo=old_hi=0.
- Start accepted at edge k:
  - First pixel is on the outputs after edge k, i.e. in cycle k+1.
  - busy=1 from cycle k+1.
- A sweep of C columns gives plot=1 for exactly C·PAD_H consecutive cycles.
- done=1 in the single cycle after the last pixel. busy=0 in that same cycle.
- IDLE is re-entered the next cycle, and start is accepted there.
- Minimum start-to-start spacing is C·PAD_H+2 cycles.

## Structure
- Shared package `paddle_pkg` holds the state enum (IDLE, DRAW, DONE) and the default geometry and colour constants.
- Sub-module `span_calc` is combinational. It takes position, old span and old_valid, and produces lo, hi, first_col and last_col. This keeps the clamp and min/max logic testable in isolation.
- Everything else stays in `paddle_renderer`: FSM, column/row counters, span registers and output registers.

## Test plan
- Full sweep, defaults: position=60, delta=0.
  - 360 plot cycles.
  - Columns 57..63 are FG, all others BG.
  - y cycles 112,113,114 per column.
  - done pulses exactly 1 cycle after the last pixel (x=119, y=114).
- Clamping:
  - position=0 → FG columns 0..6.
  - position=200 → FG columns 113..119.
  - No x value ≥120 appears.
- Delta after a full sweep at 60: request position=62, delta=1.
  - Columns 57..65, 27 plot cycles.
  - Columns 57,58 are BG; 59..65 are FG.
- Delta with old_valid=0 (immediately after reset), position=30: behaves as a full sweep of 360 pixels.
- start pulsed mid-sweep with position=10: ignored. Current sweep and span are unchanged; busy stays high.
- reset=0 asserted at pixel 100 of a sweep:
  - Next cycle all outputs are 0; no done pulse.
  - A following delta request runs as a full sweep.
